// File: rtl/hazard_unit.sv
// hazard_unit: stall, flush and forwarding control for the five-stage MIPS
// pipeline, plus the sequencer that holds the front end while the multicycle
// divider runs.
module hazard_unit #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteE,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic       memtoregE,
    input  logic       memtoregM,
    input  logic       branchD,
    input  logic       pcsrcD,
    input  logic       divE,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       div_busy
);

    localparam int unsigned CW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    logic          divstall;
    logic          lwstall;
    logic          brstall;
    logic          rs_hit_e;
    logic          rt_hit_e;
    logic          rs_hit_m;
    logic          rt_hit_m;
    logic          stall_front;

    // Divide sequencer state and busy counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next state: IDLE -> BUSY on a divide in Execute, count down, one DONE cycle.
    always_comb begin
        state_next = state;
        count_next = count;
        unique case (state)
            IDLE: begin
                if (divE) begin
                    state_next = BUSY;
                    count_next = CNT_LOAD;
                end
            end
            BUSY: begin
                if (count == '0) begin
                    state_next = DONE;
                end else begin
                    count_next = count - 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // Sequencer outputs: divide stall covers the IDLE launch cycle and all of BUSY.
    always_comb begin
        divstall = 1'b0;
        div_busy = 1'b0;
        unique case (state)
            IDLE:    divstall = divE;
            BUSY: begin
                divstall = 1'b1;
                div_busy = 1'b1;
            end
            DONE:    divstall = 1'b0;
            default: divstall = 1'b0;
        endcase
    end

    // Execute-stage forwarding: Memory result has priority over Writeback.
    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (regwriteM && (writeregM != 5'd0) && (writeregM == rsE)) begin
            forwardAE = 2'b10;
        end else if (regwriteW && (writeregW != 5'd0) && (writeregW == rsE)) begin
            forwardAE = 2'b01;
        end
        if (regwriteM && (writeregM != 5'd0) && (writeregM == rtE)) begin
            forwardBE = 2'b10;
        end else if (regwriteW && (writeregW != 5'd0) && (writeregW == rtE)) begin
            forwardBE = 2'b01;
        end
    end

    // Decode-stage comparator forwarding from the Memory result.
    always_comb begin
        forwardAD = regwriteM && (writeregM != 5'd0) && (writeregM == rsD);
        forwardBD = regwriteM && (writeregM != 5'd0) && (writeregM == rtD);
    end

    // Load-use and branch-operand hazard detection; register 0 never matches.
    always_comb begin
        rs_hit_e = (writeregE != 5'd0) && (writeregE == rsD);
        rt_hit_e = (writeregE != 5'd0) && (writeregE == rtD);
        rs_hit_m = (writeregM != 5'd0) && (writeregM == rsD);
        rt_hit_m = (writeregM != 5'd0) && (writeregM == rtD);
        lwstall  = memtoregE && (rtE != 5'd0) && ((rtE == rsD) || (rtE == rtD));
        brstall  = branchD && ((regwriteE && (rs_hit_e || rt_hit_e)) ||
                               (memtoregM && (rs_hit_m || rt_hit_m)));
    end

    // Pipeline register controls; a divide holds Execute so it never gets a bubble.
    always_comb begin
        stall_front = lwstall || brstall || divstall;
        stallF      = stall_front;
        stallD      = stall_front;
        stallE      = divstall;
        flushE      = (lwstall || brstall) && !divstall;
        flushM      = divstall;
        flushD      = pcsrcD && !stall_front;
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed scenarios plus randomized traffic against a
// cycle-timeline model of the hazard rules and divide occupancy.
module tb_hazard_unit;

    localparam int unsigned N = 4;

    logic       clk;
    logic       reset;
    logic [4:0] rsD, rtD, rsE, rtE;
    logic [4:0] writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW;
    logic       memtoregE, memtoregM;
    logic       branchD, pcsrcD, divE;
    logic       stallF, stallD, stallE;
    logic       flushD, flushE, flushM;
    logic       forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic       div_busy;

    int checks = 0;
    int errors = 0;

    // model state: divide timeline expressed as start cycle and current cycle
    bit m_active;
    int m_start;
    int m_cyc;

    hazard_unit #(.DIV_CYCLES(N)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .pcsrcD(pcsrcD), .divE(divE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .div_busy(div_busy)
    );

    logic [12:0] obs;
    assign obs = {stallF, stallD, stallE, flushD, flushE, flushM,
                  forwardAD, forwardBD, forwardAE, forwardBE, div_busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic hit(logic en, logic [4:0] w, logic [4:0] r);
        return en && (w != 5'd0) && (w == r);
    endfunction

    function automatic logic [1:0] fwd(logic [4:0] r);
        if (hit(regwriteM, writeregM, r)) return 2'd2;
        if (hit(regwriteW, writeregW, r)) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [12:0] exp_vec();
        logic ds, bz, lw, br, st;
        int k;
        if (!m_active) begin
            ds = divE;
            bz = 1'b0;
        end else begin
            k  = m_cyc - m_start;
            ds = (k < N);
            bz = (k >= 1) && (k < N);
        end
        lw = hit(memtoregE, rtE, rsD) || hit(memtoregE, rtE, rtD);
        br = branchD && (hit(regwriteE, writeregE, rsD) || hit(regwriteE, writeregE, rtD) ||
                         hit(memtoregM, writeregM, rsD) || hit(memtoregM, writeregM, rtD));
        st = lw || br || ds;
        return {st, st, ds, pcsrcD && !st, (lw || br) && !ds, ds,
                hit(regwriteM, writeregM, rsD), hit(regwriteM, writeregM, rtD),
                fwd(rsE), fwd(rtE), bz};
    endfunction

    task automatic model_step();
        if (!reset) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (divE) begin
                m_active = 1'b1;
                m_start  = m_cyc;
            end
        end else if (m_cyc - m_start == N) begin
            m_active = 1'b0;
        end
        m_cyc++;
    endtask

    task automatic advance();
        model_step();
        @(negedge clk);
    endtask

    task automatic zero_inputs();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
        regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
        memtoregE = 1'b0; memtoregM = 1'b0;
        branchD = 1'b0; pcsrcD = 1'b0; divE = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        zero_inputs();
        #1;
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp %b", obs, 13'd0);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_active = 1'b0;
        #1;
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL reset_release got %b exp %b", obs, 13'd0);
        end
        advance();
    endtask

    task automatic test_forwarding();
        zero_inputs();
        regwriteM = 1'b1; writeregM = 5'd5; regwriteW = 1'b1; writeregW = 5'd5;
        rsE = 5'd5; rtE = 5'd5; rsD = 5'd5;
        #1;
        checks++;
        if (forwardAE !== 2'b10 || forwardBE !== 2'b10 || forwardAD !== 1'b1) begin
            errors++;
            $display("FAIL fwd_m_priority got AE=%b BE=%b AD=%b exp AE=10 BE=10 AD=1",
                     forwardAE, forwardBE, forwardAD);
        end
        advance();
        writeregM = 5'd0;
        #1;
        checks++;
        if (forwardAE !== 2'b01 || forwardBE !== 2'b01 || forwardAD !== 1'b0) begin
            errors++;
            $display("FAIL fwd_w got AE=%b BE=%b AD=%b exp AE=01 BE=01 AD=0",
                     forwardAE, forwardBE, forwardAD);
        end
        advance();
        writeregW = 5'd0; rsE = 5'd0; rtE = 5'd0;
        regwriteM = 1'b1; writeregM = 5'd9; rtD = 5'd9; rsD = 5'd1;
        #1;
        checks++;
        if (forwardAE !== 2'b00 || forwardBD !== 1'b1 || forwardAD !== 1'b0) begin
            errors++;
            $display("FAIL fwd_decode got AE=%b BD=%b AD=%b exp AE=00 BD=1 AD=0",
                     forwardAE, forwardBD, forwardAD);
        end
        advance();
    endtask

    task automatic test_load_use();
        zero_inputs();
        memtoregE = 1'b1; rtE = 5'd7; rsD = 5'd7;
        #1;
        checks++;
        if ({stallF, stallD, flushE, stallE, flushM} !== 5'b11100) begin
            errors++;
            $display("FAIL load_use got F/D/fE/E/fM=%b exp 11100",
                     {stallF, stallD, flushE, stallE, flushM});
        end
        advance();
        rtE = 5'd0; rsD = 5'd0;
        #1;
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL load_use_r0 got %b exp %b", obs, 13'd0);
        end
        advance();
    endtask

    task automatic test_branch();
        zero_inputs();
        branchD = 1'b1; regwriteE = 1'b1; writeregE = 5'd3; rtD = 5'd3;
        #1;
        checks++;
        if ({stallF, stallD, flushE, stallE} !== 4'b1110) begin
            errors++;
            $display("FAIL branch_e got F/D/fE/E=%b exp 1110", {stallF, stallD, flushE, stallE});
        end
        advance();
        regwriteE = 1'b0; writeregE = 5'd0; memtoregM = 1'b1; writeregM = 5'd3; pcsrcD = 1'b1;
        #1;
        checks++;
        if ({stallF, stallD, flushE, flushD} !== 4'b1110) begin
            errors++;
            $display("FAIL branch_m got F/D/fE/fD=%b exp 1110", {stallF, stallD, flushE, flushD});
        end
        advance();
        memtoregM = 1'b0; writeregM = 5'd0;
        #1;
        checks++;
        if ({stallF, stallD, flushE, flushD} !== 4'b0001) begin
            errors++;
            $display("FAIL redirect got F/D/fE/fD=%b exp 0001", {stallF, stallD, flushE, flushD});
        end
        advance();
    endtask

    task automatic test_back_to_back();
        zero_inputs();
        for (int c = 0; c <= 10; c++) begin
            divE = (c <= 8);
            #1;
            checks++;
            if ({stallE, flushM, stallF, div_busy} !==
                {4'(((c % 5) < 4 && c < 9) ? 4'b1110 : 4'b0000) |
                 4'((((c % 5) >= 1) && ((c % 5) <= 3) && c < 9) ? 1 : 0)}) begin
                errors++;
                $display("FAIL divide cyc=%0d got E/fM/F/busy=%b", c,
                         {stallE, flushM, stallF, div_busy});
            end
            advance();
        end
    endtask

    task automatic test_div_load_use();
        zero_inputs();
        memtoregE = 1'b1; rtE = 5'd7; rsD = 5'd7;
        for (int c = 0; c <= 4; c++) begin
            divE = 1'b1;
            #1;
            checks++;
            if ({stallF, stallE, flushE, flushM} !== ((c < 4) ? 4'b1101 : 4'b1010)) begin
                errors++;
                $display("FAIL div_load_use cyc=%0d got F/E/fE/fM=%b exp %b", c,
                         {stallF, stallE, flushE, flushM}, (c < 4) ? 4'b1101 : 4'b1010);
            end
            advance();
        end
        zero_inputs();
        #1;
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL div_load_use_after got %b exp %b", obs, 13'd0);
        end
        advance();
    endtask

    task automatic test_reset_mid_div();
        zero_inputs();
        divE = 1'b1;
        advance();
        advance();
        #1;
        checks++;
        if (div_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_before_reset got %b exp 1", div_busy);
        end
        #2;
        reset = 1'b0;
        divE = 1'b0;
        #1;
        checks++;
        if (div_busy !== 1'b0 || obs !== 13'd0) begin
            errors++;
            $display("FAIL async_reset got busy=%b outs=%b exp busy=0 outs=0", div_busy, obs);
        end
        m_active = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (obs !== 13'd0) begin
                errors++;
                $display("FAIL after_reset cyc=%0d got %b exp %b", c, obs, 13'd0);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rsD = 5'($urandom_range(0, 7)); rtD = 5'($urandom_range(0, 7));
            rsE = 5'($urandom_range(0, 7)); rtE = 5'($urandom_range(0, 7));
            writeregE = 5'($urandom_range(0, 7));
            writeregM = 5'($urandom_range(0, 7));
            writeregW = 5'($urandom_range(0, 7));
            regwriteE = 1'($urandom); regwriteM = 1'($urandom); regwriteW = 1'($urandom);
            memtoregE = 1'($urandom); memtoregM = 1'($urandom);
            branchD = 1'($urandom); pcsrcD = 1'($urandom);
            divE = ($urandom_range(0, 5) == 0);
            #1;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got %b exp %b", c, obs, exp_vec());
            end
            advance();
        end
    endtask

    initial begin
        m_active = 1'b0;
        m_start  = 0;
        m_cyc    = 0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_back_to_back();
        test_div_load_use();
        test_reset_mid_div();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
